ps2_frame_rx: RTL
=================

// Module: ps2_frame_rx
// PURPOSE
//  Parametrised PS/2-style serial frame receiver for the system clock domain.
//  Frame: start(0), DATA_BITS data LSB-first, optional parity, stop(1).
//  Device drives ps2_dat while ps2_clk high; bits are sampled on ps2_clk falling edge.
//  Synchronises, deglitches and decodes frames, flags errors, and buffers words in a FIFO with a valid/ready pop port.
// PARAMETERS
//  DATA_BITS      8     data bits per frame (1..16)
//  PARITY_MODE    1     0 = none (no parity bit), 1 = odd, 2 = even
//  FIFO_DEPTH     4     receive FIFO entries, power of two >= 2
//  SYNC_STAGES    2     synchroniser flops on ps2_clk_i / ps2_dat_i (>= 2)
//  FILTER_LEN     4     cycles ps2_clk must be stable before a level change is accepted
//  TIMEOUT_CYCLES 2000  max clk cycles between falling edges inside a frame
// PORTS
//  clk          in   1          system clock
//  rst          in   1          synchronous reset, active-high
//  ps2_clk_i    in   1          async serial clock, idles high
//  ps2_dat_i    in   1          async serial data, idles high
//  rx_data      out  DATA_BITS  FIFO head word
//  rx_perr      out  1          FIFO head word had parity error
//  rx_valid     out  1          FIFO non-empty
//  rx_ready     in   1          consumer pops head when rx_valid & rx_ready
//  frame_err    out  1          1-cycle pulse: bad stop bit, frame dropped
//  timeout_err  out  1          1-cycle pulse: frame aborted by timeout
//  overflow     out  1          sticky: a good frame was dropped, FIFO full
//  err_clear    in   1          clears overflow
//  busy         out  1          high while FSM not IDLE
// BEHAVIOUR
//  Reset: FSM IDLE, FIFO empty, rx_valid=0, rx_data=0, rx_perr=0, pulses=0, overflow=0, busy=0.
//  Filtered clk (fclk) starts 1; it changes only after FILTER_LEN equal synced samples; shorter glitches ignored.
//  Falling edge = fclk 1->0; synced ps2_dat sampled that same cycle.
//  FSM (advances only on falling edges, except timeout):
//   IDLE:   sample 0 -> DATA, bit count=0; sample 1 -> stay IDLE, no error.
//   DATA:   shift in LSB-first; after DATA_BITS samples -> PARITY (or STOP if PARITY_MODE=0).
//   PARITY: perr = XOR(data, bit) != (PARITY_MODE==1) -> STOP.
//   STOP:   sample 1 -> push {perr, data}, -> IDLE; sample 0 -> frame_err, no push, -> IDLE.
//  Timeout: in non-IDLE, counter resets on each falling edge; reaching TIMEOUT_CYCLES -> timeout_err pulse, discard, IDLE.
//  Push lands in FIFO the cycle after the stop-bit edge cycle; rx_valid rises the following cycle at latest.
//  Parity-error frames are stored (rx_perr=1), not dropped.
//  Pop: when rx_valid & rx_ready, head advances next cycle; rx_data/rx_perr stable while valid & !ready.
//  Full + push, no pop: frame dropped, overflow set. Full + push + pop same cycle: both succeed.
//  Empty + push: no same-cycle bypass; a pop is never accepted while empty.
//  err_clear and an overflow event in the same cycle: overflow stays 1.
//  rst mid-frame or with FIFO occupied: everything returns to reset state next cycle; the partial frame is lost.
//  Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; full/empty come from MSB compare.
// TESTING
//  1 Frames 0x00..0x0F, odd parity, bit period 80us, rx_ready=1 -> 16 pops in order, rx_perr=0, no pulses.
//  2 Frame 0xA5 with parity bit inverted -> rx_data=0xA5, rx_perr=1; the next good frame has rx_perr=0.
//  3 Frame 0x3C with stop bit 0 -> one frame_err pulse, rx_valid stays 0.
//  4 rx_ready=0, send 5 frames 0x01..0x05 -> 0x01..0x04 held, overflow=1; pop all, err_clear -> overflow=0.
//  5 Stop ps2_clk after 4 data bits for TIMEOUT_CYCLES -> one timeout_err pulse, busy=0; next frame 0x55 is received clean.
//  6 Glitches on ps2_clk shorter than FILTER_LEN mid-frame, then rst asserted mid-frame -> glitches ignored; after rst all outputs are at reset values and the next frame 0x77 decodes.

Source files
------------

// File: rtl/ps2_frame_rx_if.sv
// Pop-side handshake of the PS/2 frame receiver: head word, its parity flag and valid/ready.
interface ps2_frame_rx_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_perr;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output rx_data,
        output rx_perr,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_perr,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2-style frame receiver: synchronise and deglitch the serial lines, decode start/data/parity/stop,
// and queue decoded words in a small FIFO with a registered-read head.
module ps2_frame_rx #(
    parameter int DATA_BITS      = 8,
    parameter int PARITY_MODE    = 1,
    parameter int FIFO_DEPTH     = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ps2_clk_i,
    input  logic           ps2_dat_i,
    ps2_frame_rx_if.master rx,
    output logic           frame_err,
    output logic           timeout_err,
    output logic           overflow,
    input  logic           err_clear,
    output logic           busy
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;
    localparam int WW  = DATA_BITS + 1;
    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic ODD_PARITY = (PARITY_MODE == 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // ------------------------------------------------------------------
    // Synchronisers (idle-high lines, so flops reset to 1)
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] dat_sync_reg;
    logic [SYNC_STAGES-1:0] clk_stage_in;
    logic [SYNC_STAGES-1:0] dat_stage_in;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign clk_stage_in[gi] = ps2_clk_i;
                assign dat_stage_in[gi] = ps2_dat_i;
            end else begin : g_rest
                assign clk_stage_in[gi] = clk_sync_reg[gi-1];
                assign dat_stage_in[gi] = dat_sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_reg <= '1;
            dat_sync_reg <= '1;
        end else begin
            clk_sync_reg <= clk_stage_in;
            dat_sync_reg <= dat_stage_in;
        end
    end

    logic clk_s;
    logic dat_s;
    assign clk_s = clk_sync_reg[SYNC_STAGES-1];
    assign dat_s = dat_sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Glitch filter: fclk follows clk_s only after FILTER_LEN consecutive differing samples
    // ------------------------------------------------------------------
    logic           fclk_reg;
    logic [FCW-1:0] filt_cnt_reg;
    logic           filt_flip;
    logic           fall;

    assign filt_flip = (clk_s != fclk_reg) && (filt_cnt_reg == FCW'(FILTER_LEN - 1));
    assign fall      = filt_flip & fclk_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            fclk_reg     <= 1'b1;
            filt_cnt_reg <= '0;
        end else if (clk_s == fclk_reg) begin
            filt_cnt_reg <= '0;
        end else if (filt_flip) begin
            fclk_reg     <= ~fclk_reg;
            filt_cnt_reg <= '0;
        end else begin
            filt_cnt_reg <= filt_cnt_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame decoder
    // ------------------------------------------------------------------
    logic [1:0]           state_reg,   state_next;
    logic [BCW-1:0]       bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg,   shift_next;
    logic                 perr_reg,    perr_next;
    logic [TCW-1:0]       timer_reg,   timer_next;
    logic                 frame_err_reg, frame_err_next;
    logic                 timeout_reg,   timeout_next;
    logic                 push_req;

    // Each data bit lands directly in its slot, so DATA_BITS=1 needs no special case.
    generate
        for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
            assign shift_next[gi] = (fall && (state_reg == ST_DATA) && (bit_cnt_reg == BCW'(gi)))
                                    ? dat_s : shift_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        perr_next      = perr_reg;
        timer_next     = timer_reg;
        frame_err_next = 1'b0;
        timeout_next   = 1'b0;
        push_req       = 1'b0;

        if (state_reg != ST_IDLE) begin
            timer_next = timer_reg + 1'b1;
        end

        if (fall) begin
            timer_next = '0;
            case (state_reg)
                ST_IDLE: begin
                    if (!dat_s) begin
                        state_next   = ST_DATA;
                        bit_cnt_next = '0;
                        perr_next    = 1'b0;
                    end
                end
                ST_DATA: begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == BCW'(DATA_BITS - 1)) begin
                        state_next = (PARITY_MODE == 0) ? ST_STOP : ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    perr_next  = (((^shift_reg) ^ dat_s) != ODD_PARITY);
                    state_next = ST_STOP;
                end
                default: begin
                    if (dat_s) begin
                        push_req = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                    state_next = ST_IDLE;
                end
            endcase
        end else if ((state_reg != ST_IDLE) && (timer_reg == TCW'(TIMEOUT_CYCLES - 1))) begin
            timeout_next = 1'b1;
            state_next   = ST_IDLE;
        end

        if (state_next == ST_IDLE) begin
            timer_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            perr_reg      <= 1'b0;
            timer_reg     <= '0;
            frame_err_reg <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            perr_reg      <= perr_next;
            timer_reg     <= timer_next;
            frame_err_reg <= frame_err_next;
            timeout_reg   <= timeout_next;
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO with registered head
    // ------------------------------------------------------------------
    logic [WW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] rd_ptr_next;
    logic [WW-1:0] rd_data_reg;
    logic          rd_valid_reg;
    logic          rd_valid_next;
    logic          overflow_reg;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          ovf_set;
    logic [WW-1:0] push_word;

    assign push_word = {perr_reg, shift_reg};
    assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop       = rd_valid_reg & rx.rx_ready;
    assign push_ok   = push_req & (~full | pop);
    assign ovf_set   = push_req & full & ~pop;

    assign rd_ptr_next = rd_ptr_reg + PW'(pop);
    // Validity lags a write by one cycle, which is exactly when the written word becomes readable.
    assign rd_valid_next = (wr_ptr_reg != rd_ptr_next);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else if (rd_valid_next) begin
            rd_data_reg <= mem[rd_ptr_next[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            rd_valid_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_reg + PW'(push_ok);
            rd_ptr_reg   <= rd_ptr_next;
            rd_valid_reg <= rd_valid_next;
            if (ovf_set) begin
                overflow_reg <= 1'b1;
            end else if (err_clear) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign rx.rx_data   = rd_data_reg[DATA_BITS-1:0];
    assign rx.rx_perr   = rd_data_reg[DATA_BITS];
    assign rx.rx_valid  = rd_valid_reg;
    assign frame_err    = frame_err_reg;
    assign timeout_err  = timeout_reg;
    assign overflow     = overflow_reg;
    assign busy         = (state_reg != ST_IDLE);

endmodule
